// File: rtl/mlp_frame_driver_pkg.sv
// Shared types and default sizing for the MLP front-end frame driver.
// Optional done watchdog is enabled with the MLP_DRV_TIMEOUT_EN macro.
package mlp_frame_driver_pkg;

  localparam int DATA_W         = 8;
  localparam int IN_DIM         = 16;
  localparam int OUTPUT_SIZE    = 10;
  localparam int CLS_W          = 4;
  localparam int TIMEOUT_CYCLES = 4096;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT,
    RESP
  } drv_state_t;

  // Index width that stays legal for a single-element vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_frame_driver_if.sv
// Host-side element stream and result stream of the MLP frame driver.
interface mlp_frame_driver_if #(
  parameter int DATA_W      = mlp_frame_driver_pkg::DATA_W,
  parameter int OUTPUT_SIZE = mlp_frame_driver_pkg::OUTPUT_SIZE,
  parameter int CLS_W       = mlp_frame_driver_pkg::CLS_W
);

  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_W-1:0]      s_data;
  logic                   s_last;

  logic                   r_valid;
  logic                   r_ready;
  logic [CLS_W-1:0]       r_class;
  logic [OUTPUT_SIZE-1:0] r_onehot;
  logic                   r_err;

  modport master (
    output s_valid, s_data, s_last, r_ready,
    input  s_ready, r_valid, r_class, r_onehot, r_err
  );

  modport slave (
    input  s_valid, s_data, s_last, r_ready,
    output s_ready, r_valid, r_class, r_onehot, r_err
  );

endinterface

// File: rtl/mlp_vec_packer.sv
// Packs streamed elements into the flat core input bus and flags frames
// whose s_last does not coincide with the final element slot.
module mlp_vec_packer #(
  parameter int DATA_W = mlp_frame_driver_pkg::DATA_W,
  parameter int IN_DIM = mlp_frame_driver_pkg::IN_DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        data,
  input  logic                     last,
  output logic [DATA_W*IN_DIM-1:0] bus,
  output logic                     frame_ok,
  output logic                     len_err
);

  localparam int IDX_W = mlp_frame_driver_pkg::idx_width(IN_DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM - 1);

  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             at_end;

  assign accept   = en & valid;
  assign at_end   = (idx_q == LAST_IDX);
  assign frame_ok = accept & at_end & last;

  // NOTE: every flop here uses <= so all reads see pre-edge values; the bus
  // is a register file but is reset so the core never sees stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      bus     <= '0;
      len_err <= 1'b0;
    end else if (accept) begin
      bus[int'(idx_q)*DATA_W +: DATA_W] <= data;
      // Either end marker closes the frame; a mismatch means it was malformed.
      if (at_end || last) idx_q <= '0;
      else                idx_q <= idx_q + 1'b1;
      if (at_end != last) len_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mlp_frame_driver.sv
// Front-end driver for the MLP core: packs a frame, pulses start, captures the
// result on the done rising edge. MLP_DRV_TIMEOUT_EN adds a done watchdog.
module mlp_frame_driver #(
  parameter int DATA_W      = mlp_frame_driver_pkg::DATA_W,
  parameter int IN_DIM      = mlp_frame_driver_pkg::IN_DIM,
  parameter int OUTPUT_SIZE = mlp_frame_driver_pkg::OUTPUT_SIZE,
  parameter int CLS_W       = mlp_frame_driver_pkg::CLS_W
`ifdef MLP_DRV_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = mlp_frame_driver_pkg::TIMEOUT_CYCLES
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mlp_frame_driver_if.slave        drv,
  output logic [DATA_W*IN_DIM-1:0] net_bus_in,
  output logic                     net_start,
  input  logic                     net_done,
  input  logic [CLS_W-1:0]         net_class_idx,
  input  logic [OUTPUT_SIZE-1:0]   net_one_out,
  output logic                     len_err,
  output logic [15:0]              frame_cnt
);

  import mlp_frame_driver_pkg::*;

  drv_state_t             state_q, state_d;
  logic                   net_done_q;
  logic                   done_edge;
  logic                   frame_ok;
  logic                   fill;
  logic                   timeout;
  logic                   handshake;
  logic [CLS_W-1:0]       class_q;
  logic [OUTPUT_SIZE-1:0] onehot_q;

  assign fill      = (state_q == FILL);
  assign done_edge = net_done & ~net_done_q;
  assign handshake = (state_q == RESP) & drv.r_ready;

  mlp_vec_packer #(
    .DATA_W (DATA_W),
    .IN_DIM (IN_DIM)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (fill),
    .valid    (drv.s_valid),
    .data     (drv.s_data),
    .last     (drv.s_last),
    .bus      (net_bus_in),
    .frame_ok (frame_ok),
    .len_err  (len_err)
  );

`ifdef MLP_DRV_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt_q <= '0;
    else if (state_q == LAUNCH) wait_cnt_q <= '0;
    else if (state_q == WAIT)   wait_cnt_q <= wait_cnt_q + 32'd1;
  end

  // A done edge in the final watchdog cycle still wins.
  assign timeout = (state_q == WAIT) && !done_edge &&
                   (wait_cnt_q >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (state_q == WAIT) begin
      if (done_edge)    err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign drv.r_err = err_q;
`else
  assign timeout   = 1'b0;
  assign drv.r_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      net_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      net_done_q <= net_done;
    end
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (frame_ok) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (done_edge || timeout) state_d = RESP;
      RESP:    if (drv.r_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Result registers only move while waiting, so they hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q  <= '0;
      onehot_q <= '0;
    end else if (state_q == WAIT) begin
      if (done_edge) begin
        class_q  <= net_class_idx;
        onehot_q <= net_one_out;
      end else if (timeout) begin
        class_q  <= '0;
        onehot_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            frame_cnt <= '0;
    else if (handshake && frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
  end

  assign drv.s_ready  = fill;
  assign net_start    = (state_q == LAUNCH);
  assign drv.r_valid  = (state_q == RESP);
  assign drv.r_class  = class_q;
  assign drv.r_onehot = onehot_q;

endmodule

// File: tb/tb_mlp_frame_driver.sv
// Self-checking bench for mlp_frame_driver with IN_DIM=4; a scoreboard queue
// holds the expected bus/result of each frame that should reach the core.
module tb_mlp_frame_driver;

  localparam int DATA_W      = 8;
  localparam int IN_DIM      = 4;
  localparam int OUTPUT_SIZE = 10;
  localparam int CLS_W       = 4;
  localparam int TO_CYCLES   = 16;

  typedef struct {
    logic [3:0][7:0]        elem;
    int                     n;
    int                     last_at;
    logic [CLS_W-1:0]       cls;
    logic [OUTPUT_SIZE-1:0] onehot;
    logic [31:0]            exp_bus;
    bit                     exp_run;
  } vec_t;

  typedef struct {
    logic [31:0]            bus;
    logic [CLS_W-1:0]       cls;
    logic [OUTPUT_SIZE-1:0] onehot;
    logic                   err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [31:0]            net_bus_in;
  logic                   net_start;
  logic                   net_done = 1'b0;
  logic [CLS_W-1:0]       net_class_idx = '0;
  logic [OUTPUT_SIZE-1:0] net_one_out = '0;
  logic                   len_err;
  logic [15:0]            frame_cnt;

  int   tests = 0;
  int   fails = 0;
  int   start_cnt = 0;
  int   exp_frames = 0;
  logic exp_len_err = 1'b0;
  exp_t exp_q[$];
  vec_t tbl[7];

  mlp_frame_driver_if #(.DATA_W(DATA_W), .OUTPUT_SIZE(OUTPUT_SIZE), .CLS_W(CLS_W)) drv_if ();

  mlp_frame_driver #(
    .DATA_W      (DATA_W),
    .IN_DIM      (IN_DIM),
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .CLS_W       (CLS_W)
`ifdef MLP_DRV_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_CYCLES)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drv           (drv_if),
    .net_bus_in    (net_bus_in),
    .net_start     (net_start),
    .net_done      (net_done),
    .net_class_idx (net_class_idx),
    .net_one_out   (net_one_out),
    .len_err       (len_err),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (net_start) start_cnt++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_elem(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!drv_if.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!drv_if.s_ready) check("s_ready_wait", 0, 1);
    drv_if.s_valid = 1'b1;
    drv_if.s_data  = d;
    drv_if.s_last  = last;
    @(posedge clk);
    #1;
    drv_if.s_valid = 1'b0;
    drv_if.s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][7:0] e, input int n, input int last_at);
    for (int i = 0; i < n; i++) send_elem(e[i], i == last_at);
  endtask

  // Checks the LAUNCH cycle (called on the negedge right after the last accept).
  task automatic check_launch(input string tag);
    check({tag, "_start_hi"}, net_start, 1);
    if (exp_q.size() > 0) check({tag, "_bus"}, net_bus_in, exp_q[0].bus);
    else check({tag, "_sb_empty"}, 0, 1);
    @(negedge clk);
    check({tag, "_start_lo"}, net_start, 0);
    check({tag, "_busy"}, drv_if.s_ready, 0);
  endtask

  task automatic core_respond(input logic [CLS_W-1:0] c, input logic [OUTPUT_SIZE-1:0] oh, input int delay);
    repeat (delay) @(negedge clk);
    net_class_idx = c;
    net_one_out   = oh;
    net_done      = 1'b1;
  endtask

  task automatic wait_result(input string tag, output int waited);
    waited = 0;
    @(negedge clk);
    while (!drv_if.r_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!drv_if.r_valid) check({tag, "_result_wait"}, 0, 1);
  endtask

  task automatic take_result(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_class"},  drv_if.r_class,  e.cls);
    check({tag, "_onehot"}, drv_if.r_onehot, e.onehot);
    check({tag, "_err"},    drv_if.r_err,    e.err);
    check({tag, "_len_err"}, len_err, exp_len_err);
    drv_if.r_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_if.r_ready = 1'b0;
    if (exp_frames < 16'hffff) exp_frames++;
    @(negedge clk);
    check({tag, "_s_ready_back"}, drv_if.s_ready, 1);
    check({tag, "_r_valid_drop"}, drv_if.r_valid, 0);
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    int waited;
    base = start_cnt;
    if (v.exp_run) exp_q.push_back('{v.exp_bus, v.cls, v.onehot, 1'b0});
    send_frame(v.elem, v.n, v.last_at);
    if (v.exp_run) begin
      @(negedge clk);
      check_launch(tag);
      core_respond(v.cls, v.onehot, 3);
      wait_result(tag, waited);
      check({tag, "_done_latency"}, waited, 0);
      take_result(tag);
      net_done = 1'b0;
    end else begin
      exp_len_err = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_no_start"}, start_cnt, base);
      check({tag, "_len_err"}, len_err, 1);
      check({tag, "_ready"}, drv_if.s_ready, 1);
    end
  endtask

  initial begin
    bit   stale;
    bit   stable;
    int   base;
    int   waited;
    vec_t v;

    drv_if.s_valid = 1'b0;
    drv_if.s_data  = '0;
    drv_if.s_last  = 1'b0;
    drv_if.r_ready = 1'b0;

    //          elements (elem[0] is the rightmost)    n  last  cls    onehot   exp bus       run
    tbl[0] = '{{8'h44, 8'h33, 8'h22, 8'h11},          4,  3,   4'd7, 10'h080, 32'h44332211, 1'b1};
    tbl[1] = '{{8'h00, 8'hff, 8'h5a, 8'ha5},          4,  3,   4'd0, 10'h001, 32'h00ff5aa5, 1'b1};
    tbl[2] = '{{8'h00, 8'hbe, 8'had, 8'hde},          3,  2,   4'd0, 10'h000, 32'h0,        1'b0};
    tbl[3] = '{{8'h04, 8'h03, 8'h02, 8'h01},          4,  3,   4'd9, 10'h200, 32'h04030201, 1'b1};
    tbl[4] = '{{8'h77, 8'h66, 8'h55, 8'h44},          4, -1,   4'd0, 10'h000, 32'h0,        1'b0};
    tbl[5] = '{{8'h87, 8'h65, 8'h43, 8'h21},          4,  3,   4'd5, 10'h020, 32'h87654321, 1'b1};
    tbl[6] = '{{8'h40, 8'h30, 8'h20, 8'h10},          4,  3,   4'd3, 10'h008, 32'h40302010, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus",       net_bus_in, 0);
    check("rst_start",     net_start, 0);
    check("rst_r_valid",   drv_if.r_valid, 0);
    check("rst_r_class",   drv_if.r_class, 0);
    check("rst_r_onehot",  drv_if.r_onehot, 0);
    check("rst_r_err",     drv_if.r_err, 0);
    check("rst_len_err",   len_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", drv_if.s_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Stale done level: must wait for a genuine rising edge.
    v = '{{8'h0d, 8'h0c, 8'h0b, 8'h0a}, 4, 3, 4'd2, 10'h004, 32'h0d0c0b0a, 1'b1};
    exp_q.push_back('{v.exp_bus, v.cls, v.onehot, 1'b0});
    @(negedge clk);
    net_done = 1'b1;
    send_frame(v.elem, v.n, v.last_at);
    @(negedge clk);
    check_launch("stale");
    stale = 1'b0;
    repeat (10) begin @(negedge clk); stale |= drv_if.r_valid; end
    net_done = 1'b0;
    repeat (10) begin @(negedge clk); stale |= drv_if.r_valid; end
    check("stale_ignored", stale, 0);
    core_respond(v.cls, v.onehot, 0);
    @(negedge clk);
    check("stale_edge_latency", drv_if.r_valid, 1);
    take_result("stale");
    net_done = 1'b0;

    // Backpressure: result and bus hold while the core inputs wander.
    v = '{{8'h3c, 8'hc3, 8'ha5, 8'h5a}, 4, 3, 4'd1, 10'h002, 32'h3cc3a55a, 1'b1};
    exp_q.push_back('{v.exp_bus, v.cls, v.onehot, 1'b0});
    send_frame(v.elem, v.n, v.last_at);
    @(negedge clk);
    check_launch("bp");
    core_respond(v.cls, v.onehot, 2);
    wait_result("bp", waited);
    net_class_idx = 4'hf;
    net_one_out   = 10'h3ff;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) net_done = 1'b0;
      if (c == 6) net_done = 1'b1;
      @(negedge clk);
      stable &= drv_if.r_valid && (drv_if.r_class == 4'd1) && (drv_if.r_onehot == 10'h002) &&
                !drv_if.s_ready && (net_bus_in == 32'h3cc3a55a);
    end
    check("bp_stable", stable, 1);
    take_result("bp");
    net_done = 1'b0;

    // Reset mid-frame: partial frame discarded, no start, counters cleared.
    base = start_cnt;
    send_elem(8'h99, 1'b0);
    send_elem(8'h88, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus",     net_bus_in, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_cnt",     frame_cnt, 0);
    exp_frames  = 0;
    exp_len_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_start", start_cnt, base);
    v = '{{8'hd4, 8'hc3, 8'hb2, 8'ha1}, 4, 3, 4'd6, 10'h040, 32'hd4c3b2a1, 1'b1};
    run_vec(v, "post_rst");

`ifdef MLP_DRV_TIMEOUT_EN
    // Watchdog: no done edge, result after TO_CYCLES cycles in WAIT.
    v = '{{8'hee, 8'hdd, 8'hcc, 8'hbb}, 4, 3, 4'd0, 10'h000, 32'heeddccbb, 1'b1};
    exp_q.push_back('{v.exp_bus, 4'd0, 10'h000, 1'b1});
    net_done      = 1'b0;
    net_class_idx = 4'd7;
    net_one_out   = 10'h080;
    send_frame(v.elem, v.n, v.last_at);
    @(negedge clk);
    check("to_start_hi", net_start, 1);
    check("to_bus", net_bus_in, 32'heeddccbb);
    stale = 1'b0;
    repeat (TO_CYCLES) begin @(negedge clk); stale |= drv_if.r_valid; end
    check("to_not_early", stale, 0);
    @(negedge clk);
    check("to_r_valid", drv_if.r_valid, 1);
    take_result("to");
    v = '{{8'h08, 8'h07, 8'h06, 8'h05}, 4, 3, 4'd8, 10'h100, 32'h08070605, 1'b1};
    run_vec(v, "after_to");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlp_frame_driver.md
Name: mlp_frame_driver

Overview:
- Front-end driver for the MLP inference core.
- Accepts input-vector elements over a valid/ready stream and packs IN_DIM elements into the flat input bus.
- Issues a one-cycle start, waits for the core's done, captures the class index and one-hot result, and returns them over a valid/ready result stream.
- Sits between the host/DMA stream and the network top.

Parameters:
- DATA_W, 8, element width in bits.
- IN_DIM, 16, elements per input vector.
- OUTPUT_SIZE, 10, number of classes (width of the one-hot result).
- CLS_W, 4, class index width.
- TIMEOUT_CYCLES, 4096, done watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  input element accepted when s_valid & s_ready.
- s_data  in  DATA_W  input element.
- s_last  in  1  marks the final element of a frame.
- net_bus_in  out  DATA_W*IN_DIM  packed vector to the core.
- net_start  out  1  one-cycle start pulse to the core.
- net_done  in  1  core done (level; may stay high between frames).
- net_class_idx  in  CLS_W  core class result.
- net_one_out  in  OUTPUT_SIZE  core one-hot result.
- r_valid  out  1  result valid.
- r_ready  in  1  result consumer ready.
- r_class  out  CLS_W  captured class index.
- r_onehot  out  OUTPUT_SIZE  captured one-hot.
- r_err  out  1  result flag: 1 = timeout abort.
- len_err  out  1  sticky frame-length error.
- frame_cnt  out  16  completed-frame counter, saturating at 0xFFFF.

Behaviour:
- Reset: all outputs 0, state FILL, element index 0, net_bus_in 0, len_err 0, frame_cnt 0.
- FSM states: FILL, LAUNCH, WAIT, RESP.
- FILL:
  - s_ready=1.
  - An accepted element idx is written to net_bus_in[idx*DATA_W +: DATA_W]; element 0 occupies the LSBs.
  - Accept with idx==IN_DIM-1 and s_last=1: go to LAUNCH.
  - Accept with s_last=1 and idx<IN_DIM-1: frame dropped, idx←0, len_err←1, stay in FILL.
  - Accept with idx==IN_DIM-1 and s_last=0: same handling (drop, idx←0, len_err←1).
- LAUNCH: s_ready=0; net_start=1 for exactly this one cycle; next state WAIT.
- WAIT:
  - s_ready=0.
  - Completion is the rising edge of net_done (net_done & ~net_done_q, where net_done_q is a register reset to 0 and updated every cycle). A done level left high from a previous frame is ignored.
  - On the edge: r_class←net_class_idx, r_onehot←net_one_out, r_err←0; go to RESP.
- RESP:
  - r_valid=1; r_class, r_onehot and r_err are held stable until r_valid & r_ready.
  - On handshake: frame_cnt+1 (saturating), idx←0, go to FILL. r_valid drops the next cycle.
- net_bus_in holds its value from LAUNCH through the exit from RESP. It changes only on FILL accepts.
- Latency:
  - Last accept to net_start: 1 cycle.
  - Done edge to r_valid: 1 cycle.
  - Fastest turnaround: s_ready reasserts the cycle after the r handshake.
- Reset asserted mid-frame: immediate return to reset state; partial frame discarded; no start pulse issued.
- Widths: idx is $clog2(IN_DIM) bits, compared against IN_DIM-1. frame_cnt does not wrap.

Optional Feature:
- Macro: MLP_DRV_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on LAUNCH and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without a done edge moves to RESP with r_err=1, r_class=0, r_onehot=0.
  - frame_cnt still increments on the handshake.
- When undefined: WAIT waits indefinitely; r_err is tied 0.

Decomposition:
- Shared package holds DATA_W, IN_DIM, OUTPUT_SIZE and data_t.
- Add to the package: CLS_W, the FSM state enum type drv_state_t, and the default TIMEOUT_CYCLES.
- One natural sub-module, mlp_vec_packer: index counter, element write into the flat bus, and length-error detection.
- The FSM, capture registers and counters stay in the top.

Test Plan (DATA_W=8, IN_DIM=4):
- Basic frame: stream 0x11,0x22,0x33,0x44, s_last on 0x44 → net_bus_in=0x44332211; net_start high exactly 1 cycle, one cycle after the last accept. Model returns done edge with class=7, onehot=0x080 → r_valid with r_class=7, r_onehot=0x080, r_err=0; frame_cnt=1.
- Stale done: hold net_done=1 from before LAUNCH, raise the edge 20 cycles later → no result until the edge; r_valid one cycle after the edge.
- Backpressure: r_ready=0 for 10 cycles → r_valid and r_class stable, s_ready=0, net_bus_in unchanged. Then r_ready=1 → s_ready=1 the next cycle.
- Length error: s_last on element 2 of 4 → no net_start, len_err=1. The next valid 4-element frame runs normally; len_err stays 1.
- Reset mid-frame: after 2 accepts, pulse rst_n low → net_bus_in=0, idx=0. A following 4-element frame produces a correct bus.
- With MLP_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=16: no done edge → r_valid at 16 WAIT cycles with r_err=1, r_class=0.
